// File: rtl/stream_scoreboard.sv
// In-order stream scoreboard: queues expected words and compares them against actual words.
// Optional per-entry compare mask is enabled by defining SCOREBOARD_MASK_EN.
module stream_scoreboard #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       exp_valid,
    output logic                       exp_ready,
    input  logic [DATA_W-1:0]          exp_data,
`ifdef SCOREBOARD_MASK_EN
    input  logic [DATA_W-1:0]          exp_mask,
`endif
    input  logic                       act_valid,
    input  logic [DATA_W-1:0]          act_data,
    output logic                       match,
    output logic                       mismatch,
    output logic [DATA_W-1:0]          first_exp,
    output logic [DATA_W-1:0]          first_act,
    output logic [31:0]                pass_count,
    output logic [31:0]                fail_count,
    output logic                       orphan,
    output logic [$clog2(DEPTH):0]     pending,
    output logic                       idle
);

    localparam int AW = $clog2(DEPTH);
`ifdef SCOREBOARD_MASK_EN
    localparam int EW = 2 * DATA_W;
`else
    localparam int EW = DATA_W;
`endif

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [EW-1:0]     mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              captured;
    logic [EW-1:0]     entry_in;
    logic [EW-1:0]     head;
    logic [DATA_W-1:0] head_data;
    logic [DATA_W-1:0] head_mask;
    logic              empty;
    logic              full;
    logic              push;
    logic              act_hit;
    logic              pop;
    logic              cmp_ok;
    logic              fail_now;

`ifdef SCOREBOARD_MASK_EN
    assign entry_in  = {exp_mask, exp_data};
    assign head_mask = head[EW-1:DATA_W];
`else
    assign entry_in  = exp_data;
    assign head_mask = '1;
`endif

    assign head      = mem[rd_ptr[AW-1:0]];
    assign head_data = head[DATA_W-1:0];

    // Occupancy flags come only from registered pointers, so exp_ready never sees act_valid.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign exp_ready = !full;
    assign pending   = wr_ptr - rd_ptr;
    assign idle      = (pending == '0) && !match && !mismatch;

    // clr drops any same-cycle transfer; an act on an empty queue is an orphan (no bypass).
    assign push     = exp_valid && exp_ready && !clr;
    assign act_hit  = act_valid && !clr;
    assign pop      = act_hit && !empty;
    assign cmp_ok   = ((head_data ^ act_data) & head_mask) == '0;
    assign fail_now = act_hit && (empty || !cmp_ok);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= entry_in;
        end
    end

    // Stage p0 -> p1: compare result, counters and captures all land on the pulse edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            match      <= 1'b0;
            mismatch   <= 1'b0;
            pass_count <= '0;
            fail_count <= '0;
            orphan     <= 1'b0;
            captured   <= 1'b0;
            first_exp  <= '0;
            first_act  <= '0;
        end else if (clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            match      <= 1'b0;
            mismatch   <= 1'b0;
            pass_count <= '0;
            fail_count <= '0;
            orphan     <= 1'b0;
            captured   <= 1'b0;
            first_exp  <= '0;
            first_act  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            match    <= pop && cmp_ok;
            mismatch <= fail_now;
            if (pop && cmp_ok) begin
                pass_count <= sat_inc(pass_count);
            end
            if (fail_now) begin
                fail_count <= sat_inc(fail_count);
            end
            if (act_hit && empty) begin
                orphan <= 1'b1;
            end
            if (fail_now && !captured) begin
                captured  <= 1'b1;
                first_exp <= empty ? '0 : head_data;
                first_act <= act_data;
            end
        end
    end

endmodule

// File: tb/tb_stream_scoreboard.sv
// Bench for stream_scoreboard: a queue model predicts each cycle's pulse, counters and captures.
module tb_stream_scoreboard;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;

    logic clk = 1'b0;
    logic rst, clr, exp_valid, act_valid;
    logic [DATA_W-1:0] exp_data, act_data;
`ifdef SCOREBOARD_MASK_EN
    logic [DATA_W-1:0] exp_mask;
`endif
    logic exp_ready, match, mismatch, orphan, idle;
    logic [DATA_W-1:0] first_exp, first_act;
    logic [31:0] pass_count, fail_count;
    logic [$clog2(DEPTH):0] pending;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] mq_d[$];
    logic [DATA_W-1:0] mq_m[$];
    logic [1:0]        res_q[$];
    logic [31:0]       m_pass, m_fail;
    logic              m_orphan, m_cap;
    logic [DATA_W-1:0] m_fexp, m_fact;

    stream_scoreboard #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .exp_valid (exp_valid),
        .exp_ready (exp_ready),
        .exp_data  (exp_data),
`ifdef SCOREBOARD_MASK_EN
        .exp_mask  (exp_mask),
`endif
        .act_valid (act_valid),
        .act_data  (act_data),
        .match     (match),
        .mismatch  (mismatch),
        .first_exp (first_exp),
        .first_act (first_act),
        .pass_count(pass_count),
        .fail_count(fail_count),
        .orphan    (orphan),
        .pending   (pending),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_clear();
        mq_d.delete();
        mq_m.delete();
        m_pass   = '0;
        m_fail   = '0;
        m_orphan = 1'b0;
        m_cap    = 1'b0;
        m_fexp   = '0;
        m_fact   = '0;
    endtask

    task automatic sample();
        logic [1:0] r;
        r = res_q.pop_front();
        check("match",      64'(match),      64'(r[1]));
        check("mismatch",   64'(mismatch),   64'(r[0]));
        check("pending",    64'(pending),    64'(mq_d.size()));
        check("pass_count", 64'(pass_count), 64'(m_pass));
        check("fail_count", 64'(fail_count), 64'(m_fail));
        check("orphan",     64'(orphan),     64'(m_orphan));
        check("first_exp",  64'(first_exp),  64'(m_fexp));
        check("first_act",  64'(first_act),  64'(m_fact));
        check("idle",       64'(idle),       64'((mq_d.size() == 0) && (r == 2'b00)));
    endtask

    // Called just after a falling edge: drives one cycle, predicts, then samples at the next fall.
    task automatic step(input logic pv, input logic [31:0] pd, input logic [31:0] pm,
                        input logic av, input logic [31:0] ad, input logic c);
        logic       ready_m;
        logic [1:0] res;
        logic [31:0] hd, hm, mk;
`ifdef SCOREBOARD_MASK_EN
        mk       = pm;
        exp_mask = pm;
`else
        mk = (pm == 32'h0) ? '1 : '1;
`endif
        exp_valid = pv;
        exp_data  = pd;
        act_valid = av;
        act_data  = ad;
        clr       = c;
        ready_m   = (mq_d.size() < DEPTH);
        check("exp_ready", 64'(exp_ready), 64'(ready_m));
        res = 2'b00;
        if (c) begin
            model_clear();
        end else begin
            if (av) begin
                if (mq_d.size() == 0) begin
                    res      = 2'b01;
                    m_orphan = 1'b1;
                    hd       = '0;
                end else begin
                    hd  = mq_d.pop_front();
                    hm  = mq_m.pop_front();
                    res = (((hd ^ ad) & hm) == '0) ? 2'b10 : 2'b01;
                end
                if (res == 2'b10) begin
                    m_pass = sat(m_pass);
                end else begin
                    m_fail = sat(m_fail);
                    if (!m_cap) begin
                        m_cap  = 1'b1;
                        m_fexp = hd;
                        m_fact = ad;
                    end
                end
            end
            if (pv && ready_m) begin
                mq_d.push_back(pd);
                mq_m.push_back(mk);
            end
        end
        res_q.push_back(res);
        @(posedge clk);
        @(negedge clk);
        exp_valid = 1'b0;
        act_valid = 1'b0;
        clr       = 1'b0;
        sample();
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; exp_valid = 1'b0; act_valid = 1'b0;
        exp_data = '0; act_data = '0;
`ifdef SCOREBOARD_MASK_EN
        exp_mask = '1;
`endif
        model_clear();
        @(negedge clk);
        @(negedge clk);
        check("rst_exp_ready",  64'(exp_ready),  64'(1));
        check("rst_match",      64'(match),      64'(0));
        check("rst_mismatch",   64'(mismatch),   64'(0));
        check("rst_pass",       64'(pass_count), 64'(0));
        check("rst_fail",       64'(fail_count), 64'(0));
        check("rst_orphan",     64'(orphan),     64'(0));
        check("rst_first_exp",  64'(first_exp),  64'(0));
        check("rst_first_act",  64'(first_act),  64'(0));
        check("rst_pending",    64'(pending),    64'(0));
        check("rst_idle",       64'(idle),       64'(1));
        rst = 1'b0;

        // In-order matches
        step(1, 32'h11, '1, 0, 0, 0);
        step(1, 32'h22, '1, 0, 0, 0);
        step(1, 32'h33, '1, 0, 0, 0);
        step(0, 0, '1, 1, 32'h11, 0);
        step(0, 0, '1, 1, 32'h22, 0);
        step(0, 0, '1, 1, 32'h33, 0);
        step(0, 0, '1, 0, 0, 0);

        // First-mismatch capture, later failure leaves it alone
        step(1, 32'hA5, '1, 0, 0, 0);
        step(1, 32'h5A, '1, 0, 0, 0);
        step(0, 0, '1, 1, 32'hA5, 0);
        step(0, 0, '1, 1, 32'hFF, 0);
        step(1, 32'h01, '1, 0, 0, 0);
        step(0, 0, '1, 1, 32'h02, 0);

        // Orphan with simultaneous push: no bypass
        step(1, 32'h77, '1, 1, 32'h77, 0);
        step(0, 0, '1, 1, 32'h77, 0);

        // Fill to full, reject 17th, push+act at full
        for (int i = 0; i < DEPTH; i++) step(1, 32'(i * 3 + 1), '1, 0, 0, 0);
        step(1, 32'hDEAD, '1, 0, 0, 0);
        step(1, 32'hBEEF, '1, 1, mq_d[0], 0);
        step(1, 32'hBEEF, '1, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, '1, 1, (i == 5) ? ~mq_d[0] : mq_d[0], 0);

        // Saturation, then clr concurrent with act
        @(negedge clk);
        res_q.push_back(2'b00);
        sample();
        force dut.fail_count = 32'hFFFF_FFFE;
        #1;
        release dut.fail_count;
        m_fail = 32'hFFFF_FFFE;
        check("fail_preload", 64'(fail_count), 64'(32'hFFFF_FFFE));
        step(0, 0, '1, 1, 32'h55, 0);
        step(0, 0, '1, 1, 32'h66, 0);
        step(1, 32'h9, '1, 1, 32'h9, 1);
        step(0, 0, '1, 0, 0, 0);

        // Random traffic with occasional clr
        for (int i = 0; i < 80; i++) begin
            logic        pv, av, c;
            logic [31:0] ad;
            pv = 1'($urandom_range(0, 1));
            av = 1'($urandom_range(0, 1));
            c  = ($urandom_range(0, 24) == 0);
            ad = 32'($urandom_range(1, 4));
            if (mq_d.size() != 0 && $urandom_range(0, 3) != 0) ad = mq_d[0];
            step(pv, 32'($urandom_range(1, 4)), '1, av, ad, c);
        end

`ifdef SCOREBOARD_MASK_EN
        step(0, 0, '1, 0, 0, 1);
        step(1, 32'h1234, 32'hFF00, 0, 0, 0);
        step(1, 32'h1234, 32'hFF00, 0, 0, 0);
        step(0, 0, '1, 1, 32'h12FF, 0);
        step(0, 0, '1, 1, 32'h13FF, 0);
`endif

        // Async reset with a comparison in flight
        step(1, 32'h44, '1, 0, 0, 0);
        exp_valid = 1'b1; exp_data = 32'h45;
        act_valid = 1'b1; act_data = 32'h44;
        #2 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exp_valid = 1'b0; act_valid = 1'b0;
        check("rstmid_match",    64'(match),      64'(0));
        check("rstmid_mismatch", 64'(mismatch),   64'(0));
        check("rstmid_pending",  64'(pending),    64'(0));
        check("rstmid_pass",     64'(pass_count), 64'(0));
        check("rstmid_idle",     64'(idle),       64'(1));
        rst = 1'b0;
        model_clear();
        res_q.delete();
        step(1, 32'h88, '1, 0, 0, 0);
        step(0, 0, '1, 1, 32'h88, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_scoreboard.md
# stream_scoreboard

In-order stream scoreboard for simulation benches; sits between a DUT output stream and the bench's end-of-test checks. Expected words are queued from the stimulus side and compared, in order, against actual words from the DUT. Each comparison produces a pass/fail pulse and a first-mismatch capture. Saturating pass/fail counters feed the bench's final equality checks.

## Interface
- DATA_W, 32, width of compared words
- DEPTH, 16, expected-queue entries; power of two, minimum 2
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous flush: empties the queue and zeroes counters, stickies and captures
- exp_valid  in  1  expected word offered
- exp_ready  out  1  queue can accept a word
- exp_data  in  DATA_W  expected word
- act_valid  in  1  actual DUT word present; always accepted, no ready
- act_data  in  DATA_W  actual word
- match  out  1  one-cycle pulse: comparison passed
- mismatch  out  1  one-cycle pulse: comparison failed or orphan
- first_exp, first_act  out  DATA_W each  operands of the first failure since reset/clr
- pass_count, fail_count  out  32 each  saturating counters
- orphan  out  1  sticky: an actual word arrived while the queue was empty
- pending  out  $clog2(DEPTH)+1  queue occupancy
- idle  out  1  pending==0 and no comparison in flight

## Operation
- Queue: circular FIFO, read/write pointers with one extra wrap bit; full = pointers equal except the wrap bit.
- Push: when exp_valid && exp_ready.
- exp_ready = !full, registered from occupancy; it never depends combinationally on act_valid. When the queue is full, a pop in the same cycle does not raise exp_ready that cycle.
- Actual word with queue non-empty: compare against the head, pop the head.
  - Equal: pass_count++.
  - Unequal: fail_count++.
- Actual word with queue empty: fail_count++, orphan set, mismatch pulses. first_exp is captured as 0 if no earlier failure.
- No bypass: a word pushed in the same cycle is not visible to a same-cycle actual word. Empty queue plus simultaneous push and act is therefore an orphan; the pushed word stays queued.
- Simultaneous push and pop on a non-empty, non-full queue: pending unchanged.
- first_exp/first_act: load only on the first failure; held until clr or rst.
- Counters saturate at 0xFFFF_FFFF and do not wrap.
- clr has priority over same-cycle push and act: those transfers are dropped, and no pulse is issued in the following cycle.
- Reset values: exp_ready=1; match=0, mismatch=0, pass_count=0, fail_count=0, orphan=0, first_exp=0, first_act=0, pending=0, idle=1.

## Timing
- Compare latency: match/mismatch assert exactly one cycle after the act_valid cycle.
- Counters and captures update on the same edge as that pulse.
- pending updates one cycle after the handshake.
- Throughput: one push and one compare per cycle, sustained.
- idle deasserts the cycle after any push or act and reasserts when the last pulse has issued and pending==0.
- Reset mid-operation: all state clears immediately (asynchronous); an in-flight pulse is suppressed.

## Configuration
- SCOREBOARD_MASK_EN defined:
  - adds input exp_mask [DATA_W-1:0], stored alongside each queued word;
  - comparison is (exp ^ act) & mask == 0; masked-off bits never fail;
  - first_act captures the raw actual word.
- Not defined: no exp_mask port; full-width compare; queue width DATA_W only.

## Test plan
- Push 0x11, 0x22, 0x33; then act 0x11, 0x22, 0x33 on consecutive cycles -> three match pulses, each one cycle after its act; pass_count=3, fail_count=0, idle=1 after the last pulse.
- Push 0xA5, 0x5A; act 0xA5, 0xFF -> match then mismatch; first_exp=0x5A, first_act=0xFF. A later failure 0x01 vs 0x02 leaves the capture unchanged.
- Act 0x77 with an empty queue while pushing 0x77 in the same cycle -> orphan=1, fail_count=1, pending=1 afterwards.
- Push 16 words -> exp_ready=0 at pending=16; a 17th offer is not accepted. Concurrent push+act at full -> exp_ready stays 0 that cycle; pending becomes 15, then the push is accepted.
- Preload fail_count near saturation (force 0xFFFF_FFFE), then two mismatches -> counter holds 0xFFFF_FFFF. Then clr concurrent with an act -> all counters 0 and no pulse the next cycle.
- With SCOREBOARD_MASK_EN: push 0x1234 with mask 0xFF00, act 0x12FF -> match; act 0x13FF against the same entry pattern -> mismatch.
